bram_drain_serializer: RTL and testbench
========================================

Name: bram_drain_serializer

Overview:
Read-side counterpart of the host word-writer on the activation BRAM. It reads 256-bit lines from the BRAM's wide port, splits each line into eight 32-bit words, and streams them out over a valid/ready interface, lowest word first. Host readback and result drain use it to recover exactly the 32-bit word sequence that was originally written. It sits between the wide BRAM port and the host/AXI-lite readback path.

Parameters:
DATA_W, 256, BRAM line width
WORD_W, 32, output word width; DATA_W/WORD_W = LANES = 8
ADDR_W, 11, BRAM line address width
READ_LATENCY, 2, cycles from enb/addrb to valid doutb (1..3 supported)

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
start_drain  in  1  one-cycle pulse; begins a drain of num_lines lines
reset_addr_counter  in  1  forces the line address counter to 0
num_lines  in  ADDR_W+1  lines per drain, sampled on start_drain
enb  out  1  BRAM read enable
addrb  out  ADDR_W  BRAM read line address
doutb  in  DATA_W  BRAM read data
m_valid  out  1  output word valid
m_ready  in  1  downstream accept
m_data  out  WORD_W  output word
busy  out  1  high from start acceptance until drain_done
drain_done  out  1  one-cycle pulse after the last word is accepted

Behaviour:
- Reset (async, rst_n=0): state IDLE; enb=0, addrb=0, m_valid=0, m_data=0, busy=0, drain_done=0; line and lane counters cleared. A reset mid-drain aborts it immediately; no pending word is preserved.
- States: IDLE -> ISSUE -> WAIT -> EMIT -> (ISSUE | DONE) -> IDLE.
- IDLE: start_drain=1 with num_lines>0 latches num_lines, sets busy=1, and moves to ISSUE. With num_lines=0, the block goes to DONE without issuing any read and emitting no beats.
- ISSUE: drives enb=1 for exactly 1 cycle with addrb equal to the current line address, then moves to WAIT.
- WAIT: counts READ_LATENCY-1 further cycles. On the cycle doutb is valid, it captures doutb into a 256-bit shift register, sets lane=0, asserts m_valid, and moves to EMIT.
- EMIT: m_data = shreg[lane*32 +: 32], so lane 0 is doutb[31:0]. m_data and m_valid stay stable while m_valid=1 and m_ready=0. Each handshake (m_valid&m_ready) advances lane.
  - On acceptance of lane 7: line address +1 and lines-remaining -1. If lines remain, m_valid drops and the block goes to ISSUE. Otherwise it goes to DONE.
  - No prefetch: there is a minimum gap of 1+READ_LATENCY cycles between lines.
- DONE: drain_done=1 for 1 cycle, busy=0, then IDLE.
- Line address persists across drains: a second start continues from the line after the last one drained. It wraps from 2^ADDR_W-1 to 0 with no error.
- reset_addr_counter is honoured only in IDLE. If it coincides with start_drain, the address clears first and the drain starts at line 0. It is ignored while busy.
- start_drain while busy is ignored, and the latched num_lines is unchanged.
- m_ready is ignored when m_valid=0. The block never asserts m_valid outside EMIT.

Test Plan:
- Preload 768 words via port A with dina=2i+2, pulse reset_addr_counter, then start with num_lines=4 and m_ready=1 -> 32 beats 2,4,...,64 in order; addrb issues 0..3; drain_done 1 cycle after the beat of value 64; busy low afterwards.
- Repeat start twice more, num_lines=4 each, with no address reset -> beats 66..128, then 130..192; addrb continues at 4..7, then 8..11.
- Backpressure: toggle m_ready pseudo-randomly -> m_data constant while stalled; the full sequence has no drops and no duplicates; beat count exactly 8*num_lines.
- num_lines=0 -> drain_done pulses, enb never asserted, m_valid stays 0.
- Pulse start_drain mid-drain and reset_addr_counter mid-drain -> both ignored, and the address sequence is unchanged. Assert rst_n=0 mid-EMIT -> m_valid=0, addrb=0, busy=0 immediately.
- Address wrap: drain 3 lines starting from line 2046 -> addrb sequence 2046, 2047, 0.

Source files
------------

// File: rtl/bram_drain_serializer_if.sv
// Word stream from the BRAM drain serializer to the host readback path.
// Plain valid/ready handshake carrying one output word per beat.
interface bram_drain_serializer_if #(
    parameter int unsigned WORD_W = 32
);
    logic              m_valid;
    logic              m_ready;
    logic [WORD_W-1:0] m_data;

    modport master (output m_valid, output m_data, input m_ready);
    modport slave  (input m_valid, input m_data, output m_ready);
endinterface

// File: rtl/bram_drain_serializer.sv
// Reads 256-bit activation BRAM lines and streams them out as 32-bit words,
// lowest word first, so host readback sees the original write order.
module bram_drain_serializer #(
    parameter int unsigned DATA_W       = 256,
    parameter int unsigned WORD_W       = 32,
    parameter int unsigned ADDR_W       = 11,
    parameter int unsigned READ_LATENCY = 2
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   start_drain,
    input  logic                   reset_addr_counter,
    input  logic [ADDR_W:0]        num_lines,
    output logic                   enb,
    output logic [ADDR_W-1:0]      addrb,
    input  logic [DATA_W-1:0]      doutb,
    output logic                   busy,
    output logic                   drain_done,
    bram_drain_serializer_if.master m
);

    localparam int unsigned LANES  = DATA_W / WORD_W;
    localparam int unsigned LANE_W = $clog2(LANES);
    localparam int unsigned CNT_W  = ADDR_W + 1;
    localparam int unsigned WAIT_W = 2;

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_ISSUE = 3'd1;
    localparam logic [2:0] S_WAIT  = 3'd2;
    localparam logic [2:0] S_EMIT  = 3'd3;
    localparam logic [2:0] S_DONE  = 3'd4;

    logic [2:0]        state,      state_n;
    logic [ADDR_W-1:0] line_addr,  line_addr_n;
    logic [CNT_W-1:0]  lines_rem,  lines_rem_n;
    logic [LANE_W-1:0] lane,       lane_n;
    logic [WAIT_W-1:0] wait_cnt,   wait_cnt_n;
    logic [DATA_W-1:0] shreg,      shreg_n;
    logic              enb_n;
    logic              m_valid_q,  m_valid_n;
    logic              busy_n;
    logic              drain_done_n;

    assign addrb     = line_addr;
    assign m.m_valid = m_valid_q;
    // The low word of the shift register is always the beat on offer.
    assign m.m_data  = shreg[WORD_W-1:0];

    // Next-state and next-output logic
    always_comb begin
        state_n     = state;
        line_addr_n = line_addr;
        lines_rem_n = lines_rem;
        lane_n      = lane;
        wait_cnt_n  = wait_cnt;
        shreg_n     = shreg;

        case (state)
            S_IDLE: begin
                // Address clear takes effect before a coincident start.
                if (reset_addr_counter) begin
                    line_addr_n = '0;
                end
                if (start_drain) begin
                    if (num_lines != '0) begin
                        lines_rem_n = num_lines;
                        state_n     = S_ISSUE;
                    end else begin
                        state_n = S_DONE;
                    end
                end
            end
            S_ISSUE: begin
                wait_cnt_n = '0;
                state_n    = S_WAIT;
            end
            S_WAIT: begin
                if (wait_cnt == WAIT_W'(READ_LATENCY - 1)) begin
                    shreg_n = doutb;
                    lane_n  = '0;
                    state_n = S_EMIT;
                end else begin
                    wait_cnt_n = wait_cnt + WAIT_W'(1);
                end
            end
            S_EMIT: begin
                if (m_valid_q && m.m_ready) begin
                    shreg_n = shreg >> WORD_W;
                    lane_n  = lane + LANE_W'(1);
                    if (lane == LANE_W'(LANES - 1)) begin
                        line_addr_n = line_addr + ADDR_W'(1);
                        lines_rem_n = lines_rem - CNT_W'(1);
                        state_n     = (lines_rem == CNT_W'(1)) ? S_DONE : S_ISSUE;
                    end
                end
            end
            S_DONE: begin
                state_n = S_IDLE;
            end
            default: begin
                state_n = S_IDLE;
            end
        endcase

        enb_n        = (state_n == S_ISSUE);
        m_valid_n    = (state_n == S_EMIT);
        busy_n       = (state_n == S_ISSUE) || (state_n == S_WAIT) || (state_n == S_EMIT);
        drain_done_n = (state_n == S_DONE);
    end

    // State and registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= S_IDLE;
            line_addr  <= '0;
            lines_rem  <= '0;
            lane       <= '0;
            wait_cnt   <= '0;
            shreg      <= '0;
            enb        <= 1'b0;
            m_valid_q  <= 1'b0;
            busy       <= 1'b0;
            drain_done <= 1'b0;
        end else begin
            state      <= state_n;
            line_addr  <= line_addr_n;
            lines_rem  <= lines_rem_n;
            lane       <= lane_n;
            wait_cnt   <= wait_cnt_n;
            shreg      <= shreg_n;
            enb        <= enb_n;
            m_valid_q  <= m_valid_n;
            busy       <= busy_n;
            drain_done <= drain_done_n;
        end
    end

endmodule

// File: tb/tb_bram_drain_serializer.sv
// Randomized bench for bram_drain_serializer: BRAM model, beat/address
// scoreboard built from line/lane arithmetic, and backpressure stalls.
module tb_bram_drain_serializer;

    localparam int unsigned DATA_W = 256;
    localparam int unsigned WORD_W = 32;
    localparam int unsigned ADDR_W = 11;
    localparam int unsigned RL     = 2;
    localparam int unsigned NLINES = 1 << ADDR_W;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              start_drain;
    logic              reset_addr_counter;
    logic [ADDR_W:0]   num_lines;
    logic              enb;
    logic [ADDR_W-1:0] addrb;
    logic [DATA_W-1:0] doutb;
    logic              busy;
    logic              drain_done;

    bram_drain_serializer_if #(.WORD_W(WORD_W)) s_if ();

    bram_drain_serializer #(
        .DATA_W(DATA_W), .WORD_W(WORD_W), .ADDR_W(ADDR_W), .READ_LATENCY(RL)
    ) dut (
        .clk(clk), .rst_n(rst_n), .start_drain(start_drain),
        .reset_addr_counter(reset_addr_counter), .num_lines(num_lines),
        .enb(enb), .addrb(addrb), .doutb(doutb), .busy(busy),
        .drain_done(drain_done), .m(s_if)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] word_of(input int line, input int lane);
        return 32'(2 * (8 * line + lane) + 2);
    endfunction

    // BRAM read port with RL cycles of latency; junk when not enabled
    logic [DATA_W-1:0] mem  [NLINES];
    logic [DATA_W-1:0] pipe [RL];
    always @(posedge clk) begin
        if (enb) pipe[0] <= mem[addrb];
        else     pipe[0] <= {8{$urandom}};
        for (int i = 1; i < RL; i++) pipe[i] <= pipe[i-1];
    end
    assign doutb = pipe[RL-1];

    bit bp = 1'b0;
    initial begin
        s_if.m_ready = 1'b1;
        forever begin
            @(posedge clk); #1;
            s_if.m_ready = bp ? 1'($urandom_range(0, 1)) : 1'b1;
        end
    end

    // Monitor, sampled on the falling edge
    logic [31:0] got_q[$];
    int          addr_q[$];
    int          cyc = 0, last_hs = 0, done_cyc = 0, done_cnt = 0;
    int          valid_cycles = 0, busy_err = 0;
    bit          prev_stall = 1'b0, busy_at_done = 1'b0;
    logic [31:0] held;
    always @(negedge clk) begin
        cyc++;
        if (!rst_n) prev_stall = 1'b0;
        else begin
            if (prev_stall) begin
                chk("stall_valid", 64'(s_if.m_valid), 64'd1);
                chk("stall_data", 64'(s_if.m_data), 64'(held));
            end
            if (s_if.m_valid && s_if.m_ready) begin
                got_q.push_back(s_if.m_data);
                last_hs = cyc;
                if (!busy) busy_err++;
            end
            if (s_if.m_valid) valid_cycles++;
            if (enb) addr_q.push_back(int'(addrb));
            if (drain_done) begin
                done_cnt++;
                done_cyc     = cyc;
                busy_at_done = busy;
            end
            prev_stall = s_if.m_valid && !s_if.m_ready;
            held       = s_if.m_data;
        end
    end

    // Reference: a drain of n lines yields words of lines a..a+n-1 (mod 2^ADDR_W)
    int          model_addr = 0;
    logic [31:0] exp_q[$];
    int          exp_addr_q[$];

    task automatic model_drain(input int n, input bit rst_addr);
        if (rst_addr) model_addr = 0;
        for (int l = 0; l < n; l++) begin
            exp_addr_q.push_back(model_addr);
            for (int k = 0; k < 8; k++) exp_q.push_back(word_of(model_addr, k));
            model_addr = (model_addr + 1) % NLINES;
        end
    endtask

    task automatic run_drain(input string tag, input int n, input bit rst_addr, input bit inject);
        int d0, t, budget;
        d0     = done_cnt;
        budget = n * 40 + 50;
        model_drain(n, rst_addr);
        @(posedge clk); #1;
        start_drain        = 1'b1;
        num_lines          = 12'(n);
        reset_addr_counter = rst_addr;
        @(posedge clk); #1;
        start_drain        = 1'b0;
        reset_addr_counter = 1'b0;
        t = 0;
        while (done_cnt == d0 && t < budget) begin
            @(negedge clk);
            t++;
            if (inject && t == 10) begin
                start_drain = 1'b1; num_lines = 12'd7; reset_addr_counter = 1'b1;
            end else if (inject && t == 11) begin
                start_drain = 1'b0; reset_addr_counter = 1'b0;
            end
        end
        start_drain = 1'b0; reset_addr_counter = 1'b0;
        chk({tag, "_done_pulses"}, 64'(done_cnt - d0), 64'd1);
        @(negedge clk);
        chk({tag, "_beats"}, 64'(got_q.size()), 64'(exp_q.size()));
        foreach (exp_q[i])
            chk({tag, "_beat"}, (i < got_q.size()) ? 64'(got_q[i]) : 64'hdead_0000_0000, 64'(exp_q[i]));
        chk({tag, "_reads"}, 64'(addr_q.size()), 64'(exp_addr_q.size()));
        foreach (exp_addr_q[i])
            chk({tag, "_addrb"}, (i < addr_q.size()) ? 64'(addr_q[i]) : 64'hffff, 64'(exp_addr_q[i]));
        if (n > 0) begin
            chk({tag, "_done_gap"}, 64'(done_cyc - last_hs), 64'd1);
            chk({tag, "_busy_at_done"}, 64'(busy_at_done), 64'd0);
            chk({tag, "_busy_during"}, 64'(busy_err), 64'd0);
        end
        got_q.delete(); addr_q.delete(); exp_q.delete(); exp_addr_q.delete();
    endtask

    initial begin
        int v0, t;
        rst_n = 1'b0; start_drain = 1'b0; reset_addr_counter = 1'b0; num_lines = '0;
        for (int l = 0; l < NLINES; l++)
            for (int k = 0; k < 8; k++) mem[l][k*32 +: 32] = word_of(l, k);

        repeat (3) @(posedge clk);
        #1;
        chk("rst_enb", 64'(enb), 64'd0);
        chk("rst_addrb", 64'(addrb), 64'd0);
        chk("rst_m_valid", 64'(s_if.m_valid), 64'd0);
        chk("rst_m_data", 64'(s_if.m_data), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_drain_done", 64'(drain_done), 64'd0);
        rst_n = 1'b1;

        @(posedge clk); #1;
        reset_addr_counter = 1'b1;
        @(posedge clk); #1;
        reset_addr_counter = 1'b0;
        model_addr = 0;

        run_drain("d1", 4, 1'b0, 1'b0);
        run_drain("d2", 4, 1'b0, 1'b0);
        run_drain("d3", 4, 1'b0, 1'b0);

        bp = 1'b1;
        run_drain("bp", int'($urandom_range(1, 6)), 1'b0, 1'b0);

        v0 = valid_cycles;
        run_drain("zero", 0, 1'b0, 1'b0);
        chk("zero_valid", 64'(valid_cycles - v0), 64'd0);

        run_drain("ignore", 4, 1'b0, 1'b1);
        run_drain("after_ignore", 2, 1'b0, 1'b0);

        // Reset in the middle of a beat stream
        @(posedge clk); #1;
        start_drain = 1'b1; num_lines = 12'd2;
        @(posedge clk); #1;
        start_drain = 1'b0;
        t = 0;
        while (!s_if.m_valid && t < 50) begin @(posedge clk); #1; t++; end
        chk("rst_emit_reached", 64'(s_if.m_valid), 64'd1);
        rst_n = 1'b0;
        #1;
        chk("rst_emit_m_valid", 64'(s_if.m_valid), 64'd0);
        chk("rst_emit_addrb", 64'(addrb), 64'd0);
        chk("rst_emit_busy", 64'(busy), 64'd0);
        chk("rst_emit_enb", 64'(enb), 64'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        got_q.delete(); addr_q.delete();
        model_addr = 0;

        // Walk up to line 2046 (address clear coincides with start), then wrap
        bp = 1'b0;
        run_drain("walk", 2046, 1'b1, 1'b0);
        bp = 1'b1;
        run_drain("wrap", 3, 1'b0, 1'b0);
        bp = 1'b0;

        repeat (3) @(posedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
